seq_serializer: RTL

Parallel-to-serial front end for the sequence-detector stage. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `seq`, the serial input of the sequence detector. It has a one-word holding register, so back-to-back words stream with no idle bit between them. `seq_valid` qualifies every bit.

---
 rtl/seq_serializer_pkg.sv | 16 +
 rtl/seq_serializer.sv | 99 +++++++++
 2 files changed

// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the sequence-detector serial front end.
package seq_pkg;

  // Shifter control states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seqState_t;

  // Default word width presented by the upstream stage
  localparam int SEQ_WIDTH = 8;

  // Default bit order on the serial line (1 = MSB first)
  localparam int SEQ_MSB_FIRST = 1;

endpackage : seq_pkg

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// streams them one bit per clock on seq. A single holding register lets the
// next word wait behind the one being shifted, so words stream back to back.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH,
  parameter int MSB_FIRST = SEQ_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             seq,
  output logic             seq_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(WIDTH - 2);

  seqState_t        r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_holdFull;
  logic             r_seqValid;
  logic             r_wordDone;

  logic             w_fire;
  logic             w_reload;
  logic [WIDTH-1:0] w_shifted;

  // The holding register is the only thing that can refuse a word.
  assign din_ready = !r_holdFull;
  assign w_fire    = din_valid && !r_holdFull;

  // A new word may enter the shifter when it is empty or on its last bit.
  assign w_reload  = (r_state == ST_IDLE) || (r_cnt == LAST_CNT);

  // Shift toward whichever end drives the serial line, filling with zeros.
  assign w_shifted = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_shreg[WIDTH-1:1]};

  assign seq       = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];
  assign seq_valid = r_seqValid;
  assign word_done = r_wordDone;
  assign busy      = (r_state == ST_SHIFT) || r_holdFull;

  // Shifter/holding-register FSM; the shifter is cleared when it goes idle so
  // that seq reads 0 whenever seq_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_seqValid <= 1'b0;
      r_wordDone <= 1'b0;
    end else if (w_reload) begin
      if (r_holdFull) begin
        r_state    <= ST_SHIFT;
        r_shreg    <= r_hold;
        r_cnt      <= '0;
        r_seqValid <= 1'b1;
        r_wordDone <= 1'b0;
        r_holdFull <= w_fire;
        if (w_fire) begin
          r_hold <= din;
        end
      end else if (w_fire) begin
        r_state    <= ST_SHIFT;
        r_shreg    <= din;
        r_cnt      <= '0;
        r_seqValid <= 1'b1;
        r_wordDone <= 1'b0;
      end else begin
        r_state    <= ST_IDLE;
        r_shreg    <= '0;
        r_cnt      <= '0;
        r_seqValid <= 1'b0;
        r_wordDone <= 1'b0;
      end
    end else begin
      r_shreg    <= w_shifted;
      r_cnt      <= r_cnt + 1'b1;
      r_wordDone <= (r_cnt == PRE_LAST_CNT);
      if (w_fire) begin
        r_hold     <= din;
        r_holdFull <= 1'b1;
      end
    end
  end

endmodule : seq_serializer
